// File: rtl/dtfag_pkg.sv
// Shared types and default constants for the DTFAG twiddle-address scheduler.
// Nothing here depends on the DTFAG_SCHED_PERF_EN build option.
package dtfag_pkg;

  localparam int RADIX   = 16;
  localparam int N_POINT = 65536;
  localparam int STAGES  = 4;
  localparam int I_W     = 2;
  localparam int J_W     = 12;
  localparam int T_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dtfag_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } dtfag_tag_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dtfag_tag_pipe.sv
// Fixed-depth delay line for the issue tags, matching the AGU plus ROM latency
// so valid/first/last line up with the twiddle on the ROM outputs.
module dtfag_tag_pipe
  import dtfag_pkg::*;
#(
  parameter int PIPE_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  dtfag_tag_t i_tag,
  output dtfag_tag_t o_tag
);

  dtfag_tag_t r_line [PIPE_LAT];

  // Shifts every cycle; consumer back-pressure never freezes the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_LAT; k++) r_line[k] <= '0;
    end else begin
      r_line[0] <= i_tag;
      for (int k = 1; k < PIPE_LAT; k++) r_line[k] <= r_line[k-1];
    end
  end

  assign o_tag = r_line[PIPE_LAT-1];

endmodule

// File: rtl/dtfag_sched.sv
// Sequencer that walks (stage, butterfly, digit) over one radix-16 transform into the AGU
// and tags ROM data. Build option DTFAG_SCHED_PERF_EN adds the stall_cnt output.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing tuples whenever tw_ready is high
// DRAIN | final tuple issued, waiting PIPE_LAT cycles for the tag line to empty
// DONE  | one-cycle done pulse, then back to IDLE
module dtfag_sched
  import dtfag_pkg::dtfag_state_t, dtfag_pkg::dtfag_tag_t, dtfag_pkg::sat_inc32;
  import dtfag_pkg::IDLE, dtfag_pkg::RUN, dtfag_pkg::DRAIN, dtfag_pkg::DONE;
#(
  parameter int STAGES   = dtfag_pkg::STAGES,
  parameter int I_W      = dtfag_pkg::I_W,
  parameter int J_W      = dtfag_pkg::J_W,
  parameter int T_W      = dtfag_pkg::T_W,
  parameter int PIPE_LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  input  logic           tw_ready,
  output logic [I_W-1:0] DTFAG_i,
  output logic [J_W-1:0] DTFAG_j,
  output logic [T_W-1:0] DTFAG_t,
  output logic           agu_en,
  output logic           tw_valid,
  output logic           tw_first,
`ifdef DTFAG_SCHED_PERF_EN
  output logic [31:0]    stall_cnt,
`endif
  output logic           tw_last
);

  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [I_W-1:0] I_LAST = I_W'(STAGES - 1);
  localparam logic [J_W-1:0] J_LAST = '1;
  localparam logic [T_W-1:0] T_LAST = T_W'(dtfag_pkg::RADIX - 1);

  dtfag_state_t   r_state;
  dtfag_state_t   w_state_nxt;
  logic [I_W-1:0] r_i;
  logic [J_W-1:0] r_j;
  logic [T_W-1:0] r_t;
  logic [DW-1:0]  r_drain;
  logic           w_issue;
  logic           w_final;
  logic           w_start_ok;
  dtfag_tag_t     w_tag_in;
  dtfag_tag_t     w_tag_out;

  assign w_final    = (r_i == I_LAST) && (r_j == J_LAST) && (r_t == T_LAST);
  assign w_start_ok = (r_state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        w_issue = tw_ready;
        if (tw_ready && w_final) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_drain == '0) w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign agu_en = w_issue;

  // Drain timer: loaded on the final issue, terminal count at zero hands over to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain <= '0;
    end else if (w_issue && w_final) begin
      r_drain <= DW'(PIPE_LAT - 1);
    end else if ((r_state == DRAIN) && (r_drain != '0)) begin
      r_drain <= r_drain - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i <= '0;
      r_j <= '0;
      r_t <= '0;
    end else if (w_start_ok || (w_issue && w_final)) begin
      r_i <= '0;
      r_j <= '0;
      r_t <= '0;
    end else if (w_issue) begin
      if (r_t == T_LAST) begin
        r_t <= '0;
        if (r_j == J_LAST) begin
          r_j <= '0;
          r_i <= r_i + I_W'(1);
        end else begin
          r_j <= r_j + J_W'(1);
        end
      end else begin
        r_t <= r_t + T_W'(1);
      end
    end
  end

  assign DTFAG_i = r_i;
  assign DTFAG_j = r_j;
  assign DTFAG_t = r_t;

  assign w_tag_in.valid = w_issue;
  assign w_tag_in.first = w_issue && (r_j == '0) && (r_t == '0);
  assign w_tag_in.last  = w_issue && w_final;

  dtfag_tag_pipe #(
    .PIPE_LAT (PIPE_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign tw_valid = w_tag_out.valid;
  assign tw_first = w_tag_out.first;
  assign tw_last  = w_tag_out.last;

`ifdef DTFAG_SCHED_PERF_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_start_ok) begin
      r_stall <= '0;
    end else if ((r_state == RUN) && !tw_ready) begin
      r_stall <= sat_inc32(r_stall);
    end
  end

  assign stall_cnt = r_stall;
`endif

endmodule
